reset_sequencer: RTL and testbench

//   Downstream of the user/power-on reset generator. Takes its resetOut pulse/level and fans it
//   out to NUM_STAGES subsystems as ordered, per-stage active-high resets.

---
 rtl/reset_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : reset_pkg
//  Description : Shared encodings and constants for the reset sequencer.
//                One-hot state encoding plus the recovery state that any
//                illegal encoding is steered back to.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_pkg;

    // One-hot, 4-bit state encoding
    typedef enum logic [3:0] {
        ST_HOLD = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } seqState_e;

    // Illegal encodings recover here, with every stage forced back into reset
    localparam seqState_e c_recoveryState = ST_HOLD;

    // Width of the externally visible stage index
    localparam int c_stageIdxW = 3;

endpackage : reset_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a bus of independent async bits.
//                Asynchronously cleared to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Fans a reset request out to NUM_STAGES subsystems, releasing
//                them in index order. Each stage waits for the previous one
//                to report ready (or time out) plus a fixed gap. Reports
//                completion and a sticky timeout error.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   resetIn,
    input  logic [NUM_STAGES-1:0]  readyIn,
    output logic [NUM_STAGES-1:0]  resetOut,
    output logic [c_stageIdxW-1:0] stageIdx,
    output logic                   seqDone,
    output logic                   timeoutErr
);

    localparam logic [CNT_W-1:0]       c_holdLast    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_gapLast     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_timeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_cntOne      = CNT_W'(1);
    localparam logic [c_stageIdxW-1:0] c_lastIdx     = c_stageIdxW'(NUM_STAGES - 1);

    seqState_e               r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [c_stageIdxW-1:0]  r_stageIdx;
    logic [NUM_STAGES-1:0]   r_resetOut;
    logic                    r_seqDone;
    logic                    r_timeoutErr;
    logic                    r_reqPrev;

    seqState_e               w_stateNext;
    logic [CNT_W-1:0]        w_cntNext;
    logic [c_stageIdxW-1:0]  w_idxNext;
    logic [c_stageIdxW-1:0]  w_idxInc;
    logic [NUM_STAGES-1:0]   w_resetOutNext;
    logic                    w_seqDoneNext;
    logic                    w_timeoutErrNext;
    logic [NUM_STAGES-1:0]   w_readySync;
    logic                    w_readyCur;

    sync_2ff #(
        .WIDTH (NUM_STAGES)
    ) u_readySync (
        .clk (clk),
        .rst (reset),
        .d   (readyIn),
        .q   (w_readySync)
    );

    assign w_idxInc = r_stageIdx + c_stageIdxW'(1);

    // Synchronised ready bit of the stage currently being awaited
    always_comb begin
        w_readyCur = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (r_stageIdx == c_stageIdxW'(j)) begin
                w_readyCur = w_readySync[j];
            end
        end
    end

    // Next-state and next-output logic; a sequence request overrides everything
    always_comb begin
        w_stateNext      = r_state;
        w_cntNext        = r_cnt;
        w_idxNext        = r_stageIdx;
        w_resetOutNext   = r_resetOut;
        w_seqDoneNext    = r_seqDone;
        w_timeoutErrNext = r_timeoutErr;

        if (resetIn) begin
            w_stateNext      = ST_HOLD;
            w_cntNext        = '0;
            w_idxNext        = '0;
            w_resetOutNext   = '1;
            w_seqDoneNext    = 1'b0;
            w_timeoutErrNext = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    // The edge that first sees the request low only arms the
                    // counter, so resetIn must then stay low HOLD_CYCLES more
                    if (!r_reqPrev) begin
                        if (r_cnt == c_holdLast) begin
                            w_resetOutNext[0] = 1'b0;
                            w_cntNext         = '0;
                            w_idxNext         = '0;
                            w_stateNext       = ST_WAIT;
                        end else begin
                            w_cntNext = r_cnt + c_cntOne;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ready wins over a simultaneous timeout
                    if (w_readyCur || (r_cnt == c_timeoutLast)) begin
                        if (!w_readyCur) begin
                            w_timeoutErrNext = 1'b1;
                        end
                        w_cntNext   = '0;
                        w_stateNext = (r_stageIdx == c_lastIdx) ? ST_DONE : ST_GAP;
                    end else begin
                        w_cntNext = r_cnt + c_cntOne;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gapLast) begin
                        for (int j = 0; j < NUM_STAGES; j++) begin
                            if (w_idxInc == c_stageIdxW'(j)) begin
                                w_resetOutNext[j] = 1'b0;
                            end
                        end
                        w_idxNext   = w_idxInc;
                        w_cntNext   = '0;
                        w_stateNext = ST_WAIT;
                    end else begin
                        w_cntNext = r_cnt + c_cntOne;
                    end
                end
                ST_DONE: begin
                    w_seqDoneNext = 1'b1;
                end
                default: begin
                    w_stateNext    = c_recoveryState;
                    w_cntNext      = '0;
                    w_idxNext      = '0;
                    w_resetOutNext = '1;
                    w_seqDoneNext  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; async reset puts every stage back into reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            r_stageIdx   <= '0;
            r_resetOut   <= '1;
            r_seqDone    <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_reqPrev    <= 1'b1;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_stageIdx   <= w_idxNext;
            r_resetOut   <= w_resetOutNext;
            r_seqDone    <= w_seqDoneNext;
            r_timeoutErr <= w_timeoutErrNext;
            r_reqPrev    <= resetIn;
        end
    end

    assign resetOut   = r_resetOut;
    assign stageIdx   = r_stageIdx;
    assign seqDone    = r_seqDone;
    assign timeoutErr = r_timeoutErr;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed bench for reset_sequencer. Expected stage releases
//                (stage, edge number) are queued as stimulus is applied and
//                matched against falling resetOut bits as they appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       resetIn;
    logic [3:0] readyIn;
    logic [3:0] resetOut;
    logic [2:0] stageIdx;
    logic       seqDone;
    logic       timeoutErr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int stage;
        int edgeNum;
    } relEvent_t;

    relEvent_t expQ[$];

    reset_sequencer #(
        .NUM_STAGES     (4),
        .HOLD_CYCLES    (16),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .resetIn    (resetIn),
        .readyIn    (readyIn),
        .resetOut   (resetOut),
        .stageIdx   (stageIdx),
        .seqDone    (seqDone),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge it holds the number of the most recent posedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectRelease(input int stage, input int edgeNum);
        relEvent_t e;
        e.stage   = stage;
        e.edgeNum = edgeNum;
        expQ.push_back(e);
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic waitSeqDone(input string tag, input int expEdge);
        int n = 0;
        while (seqDone !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, cyc, expEdge);
    endtask

    // Release monitor: each falling bit must match the head of the queue
    initial begin
        logic [3:0] prevOut;
        relEvent_t  e;
        prevOut = 4'hF;
        forever begin
            @(negedge clk);
            if (resetOut !== prevOut) begin
                for (int j = 0; j < 4; j++) begin
                    if (prevOut[j] === 1'b1 && resetOut[j] === 1'b0) begin
                        checks++;
                        assert (expQ.size() != 0) else begin
                            errors++;
                            $error("FAIL unexpectedRelease stage=%0d edge=%0d observed=released expected=held", j, cyc);
                        end
                        if (expQ.size() != 0) begin
                            e = expQ.pop_front();
                            check("release(edge*16+stage)", cyc * 16 + j, e.edgeNum * 16 + e.stage);
                        end
                    end
                end
                if ((~prevOut & resetOut) != 4'b0000) begin
                    check("riseTogether", resetOut, 4'hF);
                end
                prevOut = resetOut;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int last;

        reset   = 1'b1;
        resetIn = 1'b0;
        readyIn = 4'hF;
        repeat (2) @(negedge clk);
        check("rstResetOut", resetOut, 4'hF);
        check("rstStageIdx", stageIdx, 0);
        check("rstSeqDone", seqDone, 0);
        check("rstTimeoutErr", timeoutErr, 0);

        // Power-on sequence: stage 0 at edge 17 after reset release
        base  = cyc;
        reset = 1'b0;
        expectRelease(0, base + 17);
        expectRelease(1, base + 22);
        expectRelease(2, base + 27);
        expectRelease(3, base + 32);
        waitDrain("poweronReleases", 80);
        waitSeqDone("poweronSeqDoneEdge", base + 34);
        check("poweronTimeoutErr", timeoutErr, 0);
        check("poweronStageIdx", stageIdx, 3);
        check("poweronResetOut", resetOut, 4'h0);

        // Three-cycle resetIn pulse while DONE
        @(negedge clk);
        base    = cyc;
        resetIn = 1'b1;
        @(negedge clk);
        check("pulseResetOut", resetOut, 4'hF);
        check("pulseSeqDone", seqDone, 0);
        check("pulseStageIdx", stageIdx, 0);
        repeat (2) @(negedge clk);
        resetIn = 1'b0;
        last    = base + 3;
        expectRelease(0, last + 17);
        expectRelease(1, last + 22);
        expectRelease(2, last + 27);
        expectRelease(3, last + 32);
        waitDrain("repeatReleases", 80);
        waitSeqDone("repeatSeqDoneEdge", last + 34);

        // Stage 1 never acknowledges and times out
        @(negedge clk);
        base    = cyc;
        resetIn = 1'b1;
        readyIn = 4'b1101;
        @(negedge clk);
        resetIn = 1'b0;
        last    = base + 1;
        expectRelease(0, last + 17);
        expectRelease(1, last + 22);
        expectRelease(2, last + 34);
        expectRelease(3, last + 39);
        waitCyc(last + 29);
        check("timeoutErrBefore", timeoutErr, 0);
        waitCyc(last + 30);
        check("timeoutErrSet", timeoutErr, 1);
        waitDrain("timeoutReleases", 80);
        waitSeqDone("timeoutSeqDoneEdge", last + 41);
        check("timeoutErrInDone", timeoutErr, 1);

        // New request clears the error; a second request lands in GAP(1)
        @(negedge clk);
        base    = cyc;
        resetIn = 1'b1;
        readyIn = 4'hF;
        @(negedge clk);
        resetIn = 1'b0;
        check("timeoutErrCleared", timeoutErr, 0);
        last = base + 1;
        expectRelease(0, last + 17);
        expectRelease(1, last + 22);
        waitDrain("gapAbortReleases", 60);
        waitCyc(last + 24);
        check("inGapResetOut", resetOut, 4'b1100);
        check("inGapStageIdx", stageIdx, 1);
        resetIn = 1'b1;
        @(negedge clk);
        check("gapAbortResetOut", resetOut, 4'hF);
        check("gapAbortStageIdx", stageIdx, 0);
        check("gapAbortTimeoutErr", timeoutErr, 0);
        resetIn = 1'b0;
        last    = cyc;
        readyIn = 4'b1110;
        waitCyc(last + 12);
        check("noStage2Release", resetOut, 4'hF);

        // Async reset in the middle of WAIT(0), between clock edges
        expectRelease(0, last + 17);
        waitDrain("asyncPreReleases", 40);
        waitCyc(last + 20);
        check("midWaitResetOut", resetOut, 4'b1110);
        #2;
        reset   = 1'b1;
        readyIn = 4'b1000;
        #1;
        check("asyncResetOut", resetOut, 4'hF);
        check("asyncStageIdx", stageIdx, 0);
        @(negedge clk);
        base  = cyc;
        reset = 1'b0;

        // Ready pulse on stage 0, stage 3 ready early
        expectRelease(0, base + 17);
        expectRelease(1, base + 26);
        expectRelease(2, base + 34);
        expectRelease(3, base + 39);
        waitCyc(base + 19);
        readyIn = 4'b1001;
        waitCyc(base + 23);
        readyIn = 4'b1000;
        waitCyc(base + 27);
        check("earlyReadyResetOut", resetOut, 4'b1100);
        readyIn = 4'b1110;
        waitDrain("orderedReleases", 80);
        waitSeqDone("orderedSeqDoneEdge", base + 41);
        check("orderedTimeoutErr", timeoutErr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
